orientation_loader: RTL and testbench

- Upstream neighbour of the cube display core.
- Receives the cube orientation from the microcontroller over the sck/sdi/load serial link, resynchronised into the clk domain.
- Validates the received frame: length, colour codes, and exactly 9 stickers per colour.
- Only after a frame passes validation does it update the stable orientation register and pulse frame_valid, which restarts the display core. Bad frames are dropped and reported.

---
 rtl/orientation_loader.sv | 158 +++++++++++++++
 tb/tb_orientation_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/orientation_loader.sv
// Serial orientation receiver for the cube display: resynchronises the MCU link,
// shifts in a frame, validates sticker codes and colour counts, and commits only good frames.
module orientation_loader #(
    parameter int NBITS     = 162,
    parameter int NSTICKERS = 54,
    parameter int PER_COLOR = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             sdi,
    input  logic             load,
    output logic [NBITS-1:0] orientation,
    output logic             frame_valid,
    output logic             frame_error,
    output logic [1:0]       err_code,
    output logic             busy
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sck_sync_q, sdi_sync_q, load_sync_q;
    logic             sck_prev_q, load_prev_q;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [NBITS-1:0] orient_q, orient_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [5:0]       idx_q, idx_d;
    logic [5:0][3:0]  tally_q, tally_d;
    logic             illegal_q, illegal_d;
    logic [1:0]       err_q, err_d;

    logic       sck_s, sdi_s, load_s;
    logic       sck_rise, load_rise, load_fall;
    logic       len_bad, count_bad;
    logic [2:0] code;

    assign sck_s     = sck_sync_q[1];
    assign sdi_s     = sdi_sync_q[1];
    assign load_s    = load_sync_q[1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign load_rise = load_s & ~load_prev_q;
    assign load_fall = ~load_s & load_prev_q;
    assign len_bad   = (cnt_q != 8'(NBITS));
    assign code      = shift_q[3*idx_q +: 3];

    always_comb begin
        count_bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (tally_q[c] != 4'(PER_COLOR)) count_bad = 1'b1;
        end
    end

    // State register plus all datapath registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sck_sync_q  <= '0;
            sdi_sync_q  <= '0;
            load_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            load_prev_q <= 1'b0;
            shift_q     <= '0;
            orient_q    <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            tally_q     <= '0;
            illegal_q   <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= {sck_sync_q[0], sck};
            sdi_sync_q  <= {sdi_sync_q[0], sdi};
            load_sync_q <= {load_sync_q[0], load};
            sck_prev_q  <= sck_s;
            load_prev_q <= load_s;
            shift_q     <= shift_d;
            orient_q    <= orient_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            tally_q     <= tally_d;
            illegal_q   <= illegal_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (load_rise) state_d = S_SHIFT;
            S_SHIFT:  if (load_fall) state_d = len_bad ? S_ERROR : S_CHECK;
            S_CHECK:  if (idx_q == 6'(NSTICKERS - 1)) state_d = S_COMMIT;
            S_COMMIT: state_d = (illegal_q || count_bad) ? S_ERROR : S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next-state; err_d is loaded on entry to ERROR so the code is valid with the pulse.
    always_comb begin
        shift_d   = shift_q;
        orient_d  = orient_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tally_d   = tally_q;
        illegal_d = illegal_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (load_rise) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (sck_rise && load_s) begin
                    shift_d = {shift_q[NBITS-2:0], sdi_s};
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
                if (load_fall) begin
                    idx_d     = '0;
                    tally_d   = '0;
                    illegal_d = 1'b0;
                    if (len_bad) err_d = 2'b01;
                end
            end
            S_CHECK: begin
                if (code > 3'd5) begin
                    illegal_d = 1'b1;
                end else if (tally_q[code] != 4'hF) begin
                    tally_d[code] = tally_q[code] + 4'd1;
                end
                if (idx_q != 6'(NSTICKERS - 1)) idx_d = idx_q + 6'd1;
            end
            S_COMMIT: begin
                if (illegal_q)      err_d    = 2'b10;
                else if (count_bad) err_d    = 2'b11;
                else                orient_d = shift_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        frame_valid = (state_q == S_COMMIT) && !illegal_q && !count_bad;
        frame_error = (state_q == S_ERROR);
        busy        = (state_q == S_CHECK) || (state_q == S_COMMIT);
    end

    assign orientation = orient_q;
    assign err_code    = err_q;

endmodule

// File: tb/tb_orientation_loader.sv
// Bench for orientation_loader: random serial frames, a frame-level reference model,
// and a monitor that pops expected commit/reject events as the DUT pulses.
module tb_orientation_loader;
  localparam int NBITS = 162;
  localparam int NST   = 54;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic load = 1'b0;
  logic [NBITS-1:0] orientation;
  logic frame_valid, frame_error, busy;
  logic [1:0] err_code;

  orientation_loader #(.NBITS(NBITS), .NSTICKERS(NST), .PER_COLOR(9)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load),
    .orientation(orientation), .frame_valid(frame_valid), .frame_error(frame_error),
    .err_code(err_code), .busy(busy)
  );

  // clock / reset
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic             is_valid;
    logic [1:0]       code;
    logic [NBITS-1:0] prev;
    logic [NBITS-1:0] orient;
    int               at;
  } exp_t;

  exp_t exp_q[$];
  logic tx_q[$];
  logic [2:0] st[NST];
  logic [NBITS-1:0] model_orient = '0;
  logic [1:0] model_err = 2'b00;
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // reference model: judge the whole frame from its bit list
  task automatic predict(input int t);
    exp_t e;
    logic [NBITS-1:0] f;
    logic [2:0] c;
    int cnt[6];
    bit illegal, cbad;
    f = '0;
    illegal = 0;
    cbad = 0;
    for (int i = 0; i < 6; i++) cnt[i] = 0;
    e.is_valid = 1'b0;
    if (tx_q.size() != NBITS) begin
      e.code = 2'b01;
      e.at = t + 1;
    end else begin
      for (int i = 0; i < NBITS; i++) f[NBITS-1-i] = tx_q[i];
      for (int k = 0; k < NST; k++) begin
        c = f[3*k +: 3];
        if (c > 3'd5) illegal = 1;
        else cnt[c]++;
      end
      for (int i = 0; i < 6; i++) if (cnt[i] != 9) cbad = 1;
      e.at = t + 56;
      if (illegal) e.code = 2'b10;
      else if (cbad) e.code = 2'b11;
      else begin
        e.is_valid = 1'b1;
        e.at = t + 55;
      end
    end
    e.prev = model_orient;
    if (e.is_valid) begin
      model_orient = f;
      e.code = model_err;
    end else begin
      model_err = e.code;
    end
    e.orient = model_orient;
    exp_q.push_back(e);
  endtask

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic make_tx();
    tx_q.delete();
    for (int k = NST - 1; k >= 0; k--)
      for (int b = 2; b >= 0; b--) tx_q.push_back(st[k][b]);
  endtask

  task automatic solved();
    for (int k = 0; k < NST; k++) st[k] = 3'(k / 9);
  endtask

  task automatic shuffle();
    logic [2:0] tmp;
    int j;
    for (int k = NST - 1; k > 0; k--) begin
      j = $urandom_range(0, k);
      tmp = st[k];
      st[k] = st[j];
      st[j] = tmp;
    end
  endtask

  task automatic send_bits(input int half, input int nbits);
    load = 1'b1;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      sdi = tx_q[i];
      wait_clk(half);
      sck = 1'b1;
      wait_clk(half);
      sck = 1'b0;
    end
    wait_clk(half);
  endtask

  task automatic end_frame();
    load = 1'b0;
    predict(cyc + 2);
  endtask

  task automatic run_frame(input int half);
    send_bits(half, tx_q.size());
    end_frame();
    wait_clk(70);
  endtask

  // monitor / scoreboard
  exp_t got;
  logic orient_pending = 1'b0;
  logic [NBITS-1:0] orient_next;
  always @(negedge clk) begin
    if (reset) begin
      if (orient_pending) begin
        check("orient_after_commit", orientation, orient_next);
        orient_pending = 1'b0;
      end
      if (frame_valid || frame_error) begin
        check("valid_error_exclusive", NBITS'(frame_valid & frame_error), '0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: valid=%0b error=%0b, required no pulse", frame_valid, frame_error);
        end else begin
          got = exp_q.pop_front();
          check("pulse_kind", NBITS'(frame_valid), NBITS'(got.is_valid));
          check("pulse_cycle", NBITS'(cyc), NBITS'(got.at));
          check("err_code", NBITS'(err_code), NBITS'(got.code));
          check("busy_at_pulse", NBITS'(busy), NBITS'(got.is_valid));
          if (got.is_valid) begin
            check("orient_in_commit", orientation, got.prev);
            orient_pending = 1'b1;
            orient_next = got.orient;
          end else begin
            check("orient_kept", orientation, got.orient);
          end
        end
      end
    end
  end

  initial begin
    int mode, half;
    reset = 1'b0;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(2);
    check("reset_orient", orientation, '0);
    check("reset_err", NBITS'(err_code), '0);
    check("reset_busy", NBITS'(busy), '0);
    check("reset_pulses", NBITS'({frame_valid, frame_error}), '0);

    solved(); make_tx(); run_frame(4);
    solved(); make_tx(); void'(tx_q.pop_back()); run_frame(4);

    // reset in the middle of a frame
    solved(); make_tx();
    send_bits(4, 40);
    reset = 1'b0;
    load = 1'b0;
    sck = 1'b0;
    wait_clk(2);
    reset = 1'b1;
    model_orient = '0;
    model_err = 2'b00;
    wait_clk(2);
    check("midreset_orient", orientation, '0);
    check("midreset_err", NBITS'(err_code), '0);
    check("midreset_busy", NBITS'(busy), '0);
    wait_clk(4);

    solved(); make_tx(); run_frame(4);
    solved(); make_tx(); void'(tx_q.pop_back()); run_frame(4);
    solved(); make_tx(); tx_q.push_back(1'($urandom_range(0, 1))); run_frame(4);
    solved(); st[17] = 3'b110; make_tx(); run_frame(4);
    solved(); st[0] = 3'd2; make_tx(); run_frame(4);

    for (int r = 0; r < 10; r++) begin
      mode = $urandom_range(0, 3);
      half = $urandom_range(3, 5);
      solved(); shuffle();
      if (mode == 1) st[$urandom_range(0, NST - 1)] = 3'($urandom_range(0, 7));
      if (mode == 2) for (int k = 0; k < NST; k++) st[k] = 3'($urandom_range(0, 7));
      make_tx();
      if (mode == 3) begin
        tx_q.delete();
        for (int i = $urandom_range(150, 170); i > 0; i--) tx_q.push_back(1'($urandom_range(0, 1)));
      end
      run_frame(half);
    end

    // load re-raised during CHECK must be ignored
    solved(); shuffle(); make_tx();
    send_bits(3, tx_q.size());
    end_frame();
    wait_clk(12);
    load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sck = 1'b1; wait_clk(3);
      sck = 1'b0; wait_clk(3);
    end
    load = 1'b0;
    wait_clk(70);
    solved(); shuffle(); make_tx(); run_frame(3);

    wait_clk(100);
    check("queue_drained", NBITS'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
